// File: rtl/macroblock_scheduler.sv
// Macroblock scheduler: tiles a frame into 64/32/16-pixel blocks and issues clipped block
// descriptors over valid/ready. Optional: MACROBLOCK_SCHEDULER_SERPENTINE_EN (odd rows right-to-left).
package macroblock_scheduler_pkg;
    typedef enum logic [1:0] {
        MBLK_ILLEGAL = 2'b00,
        MBLK64X64    = 2'b01,
        MBLK32X32    = 2'b10,
        MBLK16X16    = 2'b11
    } te_macro_block_type_e;
endpackage

module macroblock_scheduler
    import macroblock_scheduler_pkg::*;
#(
    parameter int W_DIM = 12,
    parameter int W_IDX = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic [W_DIM-1:0] iFrameW,
    input  logic [W_DIM-1:0] iFrameH,
    input  logic [1:0]       iMbType,
    output logic             oBusy,
    output logic             oMbValid,
    input  logic             iMbReady,
    output logic [W_DIM-1:0] oMbX,
    output logic [W_DIM-1:0] oMbY,
    output logic [6:0]       oMbW,
    output logic [6:0]       oMbH,
    output logic [W_IDX-1:0] oMbIdx,
    output logic             oMbLast,
    output logic             oDone,
    output logic             oErr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [W_DIM-1:0] frame_w_q, frame_w_d;
    logic [W_DIM-1:0] frame_h_q, frame_h_d;
    logic [2:0]       shift_q, shift_d;
    logic [W_DIM-1:0] cols_q, cols_d;
    logic [W_DIM-1:0] rows_q, rows_d;
    logic [W_DIM-1:0] col_q, col_d;
    logic [W_DIM-1:0] row_q, row_d;
    logic [W_DIM-1:0] x_q, x_d;
    logic [W_DIM-1:0] y_q, y_d;
    logic [W_IDX-1:0] idx_q, idx_d;

    logic [W_DIM-1:0] mb_size;
    logic [W_DIM:0]   w_round, h_round;
    logic [W_DIM-1:0] cols_calc, rows_calc;
    logic [W_DIM-1:0] rem_w, rem_h;
    logic [W_DIM-1:0] clip_w, clip_h;
    logic [W_DIM-1:0] row_start_x;
    logic             last_col, last_blk;
    logic             valid;

    // Block size is a power of two, so tile counts reduce to round-up-and-shift.
    always_comb begin
        mb_size     = W_DIM'(1) << shift_q;
        w_round     = {1'b0, frame_w_q} + {1'b0, mb_size} - (W_DIM+1)'(1);
        h_round     = {1'b0, frame_h_q} + {1'b0, mb_size} - (W_DIM+1)'(1);
        cols_calc   = W_DIM'(w_round >> shift_q);
        rows_calc   = W_DIM'(h_round >> shift_q);
        rem_w       = frame_w_q - x_q;
        rem_h       = frame_h_q - y_q;
        clip_w      = (rem_w >= mb_size) ? mb_size : rem_w;
        clip_h      = (rem_h >= mb_size) ? mb_size : rem_h;
        row_start_x = (cols_q - W_DIM'(1)) << shift_q;
        last_col    = (col_q == cols_q - W_DIM'(1));
        last_blk    = last_col && (row_q == rows_q - W_DIM'(1));
    end

    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        frame_w_d = frame_w_q;
        frame_h_d = frame_h_q;
        shift_d   = shift_q;
        cols_d    = cols_q;
        rows_d    = rows_q;
        col_d     = col_q;
        row_d     = row_q;
        x_d       = x_q;
        y_d       = y_q;
        idx_d     = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iStart && !iAbort) begin
                    frame_w_d = iFrameW;
                    frame_h_d = iFrameH;
                    unique case (te_macro_block_type_e'(iMbType))
                        MBLK32X32: shift_d = 3'd5;
                        MBLK16X16: shift_d = 3'd4;
                        default:   shift_d = 3'd6;
                    endcase
                    if (iMbType == MBLK_ILLEGAL || iFrameW == '0 || iFrameH == '0)
                        state_d = ST_ERR;
                    else
                        state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cols_d  = cols_calc;
                rows_d  = rows_calc;
                col_d   = '0;
                row_d   = '0;
                x_d     = '0;
                y_d     = '0;
                idx_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (iMbReady) begin
                    idx_d = idx_q + W_IDX'(1);
                    if (last_blk) begin
                        state_d = ST_DONE;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + W_DIM'(1);
                        y_d   = y_q + mb_size;
`ifdef MACROBLOCK_SCHEDULER_SERPENTINE_EN
                        x_d   = row_q[0] ? '0 : row_start_x;
`else
                        x_d   = '0;
`endif
                    end else begin
                        col_d = col_q + W_DIM'(1);
`ifdef MACROBLOCK_SCHEDULER_SERPENTINE_EN
                        x_d   = row_q[0] ? (x_q - mb_size) : (x_q + mb_size);
`else
                        x_d   = x_q + mb_size;
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (iAbort)
            state_d = ST_IDLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            frame_w_q <= '0;
            frame_h_q <= '0;
            shift_q   <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            frame_w_q <= frame_w_d;
            frame_h_q <= frame_h_d;
            shift_q   <= shift_d;
            cols_q    <= cols_d;
            rows_q    <= rows_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
        end
    end

    // Descriptor fields are forced to zero whenever no block is being offered.
    always_comb begin
        valid    = (state_q == ST_ISSUE);
        oMbValid = valid;
        oMbX     = valid ? x_q : '0;
        oMbY     = valid ? y_q : '0;
        oMbW     = valid ? 7'(clip_w) : '0;
        oMbH     = valid ? 7'(clip_h) : '0;
        oMbIdx   = valid ? idx_q : '0;
        oMbLast  = valid && last_blk;
        oBusy    = (state_q == ST_SETUP) || (state_q == ST_ISSUE) || (state_q == ST_DONE);
        oDone    = (state_q == ST_DONE);
        oErr     = (state_q == ST_ERR);
    end

endmodule

// File: tb/tb_macroblock_scheduler.sv
// Directed bench for macroblock_scheduler: raster tiling, clipping, backpressure, errors,
// abort and reset recovery; serpentine order expected when MACROBLOCK_SCHEDULER_SERPENTINE_EN is set.
module tb_macroblock_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [11:0] frame_w;
    logic [11:0] frame_h;
    logic [1:0]  mb_type;
    logic        busy;
    logic        mb_valid;
    logic        mb_ready;
    logic [11:0] mb_x;
    logic [11:0] mb_y;
    logic [6:0]  mb_w;
    logic [6:0]  mb_h;
    logic [15:0] mb_idx;
    logic        mb_last;
    logic        done;
    logic        err;

    int n_checks;
    int n_bad;

    int exp_x [16];
    int exp_y [16];
    int exp_w [16];
    int exp_h [16];

    macroblock_scheduler #(.W_DIM(12), .W_IDX(16)) dut (
        .iClk     (clk),
        .iRst     (rst),
        .iStart   (start),
        .iAbort   (abort),
        .iFrameW  (frame_w),
        .iFrameH  (frame_h),
        .iMbType  (mb_type),
        .oBusy    (busy),
        .oMbValid (mb_valid),
        .iMbReady (mb_ready),
        .oMbX     (mb_x),
        .oMbY     (mb_y),
        .oMbW     (mb_w),
        .oMbH     (mb_h),
        .oMbIdx   (mb_idx),
        .oMbLast  (mb_last),
        .oDone    (done),
        .oErr     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_exp(input int i, input int x, input int y, input int w, input int h);
        exp_x[i] = x;
        exp_y[i] = y;
        exp_w[i] = w;
        exp_h[i] = h;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(mb_valid), 0);
        check({tag, "_busy"},  32'(busy),     0);
        check({tag, "_done"},  32'(done),     0);
        check({tag, "_err"},   32'(err),      0);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 0,0,1 repeating.
    task automatic run_frame(input string name, input logic [11:0] w, input logic [11:0] h,
                             input logic [1:0] t, input int n_exp, input int mode);
        int n;
        int valid_cycles;
        int dones;
        @(negedge clk);
        frame_w  = w;
        frame_h  = h;
        mb_type  = t;
        mb_ready = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_lat_valid"}, 32'(mb_valid), 0);
        check({name, "_lat_busy"},  32'(busy),     1);
        n = 0;
        valid_cycles = 0;
        dones = 0;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            @(negedge clk);
            mb_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
            if (cyc == 0)
                check({name, "_first_valid"}, 32'(mb_valid), 1);
            if (mb_valid) begin
                valid_cycles++;
                if (n < n_exp) begin
                    check($sformatf("%s_x[%0d]", name, n),    32'(mb_x),    32'(exp_x[n]));
                    check($sformatf("%s_y[%0d]", name, n),    32'(mb_y),    32'(exp_y[n]));
                    check($sformatf("%s_w[%0d]", name, n),    32'(mb_w),    32'(exp_w[n]));
                    check($sformatf("%s_h[%0d]", name, n),    32'(mb_h),    32'(exp_h[n]));
                    check($sformatf("%s_idx[%0d]", name, n),  32'(mb_idx),  32'(n));
                    check($sformatf("%s_last[%0d]", name, n), 32'(mb_last), 32'(n == n_exp - 1));
                    check($sformatf("%s_busy[%0d]", name, n), 32'(busy),    1);
                end else begin
                    check({name, "_extra_block"}, 32'(n), 32'(n_exp - 1));
                end
                if (mb_ready)
                    n++;
            end
            if (done) begin
                dones++;
                check({name, "_done_valid"}, 32'(mb_valid), 0);
                check({name, "_done_busy"},  32'(busy),     1);
            end
        end
        check({name, "_blocks"}, 32'(n), 32'(n_exp));
        check({name, "_dones"},  32'(dones), 1);
        check({name, "_valid_cycles"}, 32'(valid_cycles), 32'((mode == 0) ? n_exp : 3 * n_exp));
        @(negedge clk);
        mb_ready = 1'b0;
        check_idle({name, "_after"});
    endtask

    task automatic load_16x4x4();
        for (int i = 0; i < 16; i++)
            set_exp(i, (i % 4) * 16, (i / 4) * 16, 16, 16);
    endtask

    initial begin
        int n;
        int dones;
        n_checks = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        frame_w  = '0;
        frame_h  = '0;
        mb_type  = '0;
        mb_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_x",    32'(mb_x),    0);
        check("reset_w",    32'(mb_w),    0);
        check("reset_idx",  32'(mb_idx),  0);
        check("reset_last", 32'(mb_last), 0);
        rst = 1'b0;

        // 128x64 with 64x64 blocks
        set_exp(0, 0,  0, 64, 64);
        set_exp(1, 64, 0, 64, 64);
        run_frame("f128x64", 12'd128, 12'd64, 2'b01, 2, 0);

        // 100x40 with 32x32 blocks: partial last column and row
        for (int i = 0; i < 8; i++)
            set_exp(i, (i % 4) * 32, (i / 4) * 32, (i % 4 == 3) ? 4 : 32, (i >= 4) ? 8 : 32);
        run_frame("f100x40", 12'd100, 12'd40, 2'b10, 8, 0);
        run_frame("bp100x40", 12'd100, 12'd40, 2'b10, 8, 1);

        // Single block frame
        set_exp(0, 0, 0, 20, 10);
        run_frame("single", 12'd20, 12'd10, 2'b01, 1, 0);

        // Illegal configurations
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            frame_w = (k == 1) ? 12'd0 : 12'd128;
            frame_h = (k == 2) ? 12'd0 : 12'd64;
            mb_type = (k == 0) ? 2'b00 : 2'b01;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("err%0d_pulse", k), 32'(err),      1);
            check($sformatf("err%0d_busy", k),  32'(busy),     0);
            check($sformatf("err%0d_valid", k), 32'(mb_valid), 0);
            @(negedge clk);
            check_idle($sformatf("err%0d_after", k));
        end

        // Abort after the third transfer of a 16-block frame
        load_16x4x4();
        @(negedge clk);
        frame_w  = 12'd64;
        frame_h  = 12'd64;
        mb_type  = 2'b11;
        start    = 1'b1;
        mb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
            @(negedge clk);
            if (mb_valid && mb_ready)
                n++;
        end
        check("abort_pre_transfers", 32'(n), 3);
        @(negedge clk);
        check("abort_pre_idx", 32'(mb_idx), 3);
        check("abort_pre_x",   32'(mb_x),   48);
        abort    = 1'b1;
        mb_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_next");
        dones = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (done || mb_valid || err)
                dones++;
        end
        check("abort_quiet", 32'(dones), 0);

        // Restart after abort, then reset mid-frame
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("restart_valid", 32'(mb_valid), 1);
        check("restart_idx",   32'(mb_idx),   0);
        check("restart_x",     32'(mb_x),     0);
        check("restart_y",     32'(mb_y),     0);
        mb_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("prerst_idx", 32'(mb_idx), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mb_ready = 1'b0;
        check_idle("midrst");
        check("midrst_idx", 32'(mb_idx), 0);
        run_frame("after_rst", 12'd64, 12'd64, 2'b11, 16, 0);

        // 64x32 with 16x16 blocks: traversal order depends on build option
`ifdef MACROBLOCK_SCHEDULER_SERPENTINE_EN
        for (int i = 0; i < 4; i++) begin
            set_exp(i,     i * 16,       0,  16, 16);
            set_exp(i + 4, 48 - i * 16,  16, 16, 16);
        end
`else
        for (int i = 0; i < 8; i++)
            set_exp(i, (i % 4) * 16, (i / 4) * 16, 16, 16);
`endif
        run_frame("order64x32", 12'd64, 12'd32, 2'b11, 8, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
